xof_seed_sequencer: RTL
=======================

Name: xof_seed_sequencer

Overview:
- Parametrised seed store and XOF input sequencer between the Keccak core and the sampler front end (rejection parser / CBD).
- Holds NUM_SEEDS seeds (e.g. slot 0 = rho, slot 1 = sigma), each loaded word-by-word from Keccak output.
- On request, streams a selected seed followed by one nonce word into the Keccak absorb port, with valid/ack handshake and last marking.
- Generalises the fixed two-seed, XOR-nonce scheme to N seeds of configurable length, with a properly appended nonce word.

Parameters:
- DATA_W, 64, word width of the load and stream datapaths.
- SEED_WORDS, 4, words per seed (4 x 64 = 256-bit seed).
- NUM_SEEDS, 2, number of seed slots.
- NONCE_W, 16, nonce width; must be <= DATA_W. Packed as {j,i} bytes for matrix sampling and {8'h00,N} for noise sampling.
- SEL_W, 1, slot select width; must be >= clog2(NUM_SEEDS).

Ports:
- clk  in  1  clock, rising edge.
- resetb  in  1  asynchronous reset, active low.
- load_clear  in  1  invalidates slot load_sel and zeroes its write pointer.
- load_valid  in  1  load_data is valid this cycle.
- load_sel  in  SEL_W  slot to load or clear.
- load_data  in  DATA_W  seed word from Keccak out.
- load_ready  out  1  load/clear accepted this cycle.
- seed_loaded  out  NUM_SEEDS  per-slot complete flag.
- req_valid  in  1  stream request.
- req_sel  in  SEL_W  seed slot to stream.
- req_nonce  in  NONCE_W  nonce for this stream.
- req_ready  out  1  high in IDLE.
- req_err  out  1  one-cycle pulse: request rejected.
- out_valid  out  1  stream word valid, to Keccak in_valid.
- out_data  out  DATA_W  stream word, to Keccak in.
- out_last  out  1  final word of stream, to Keccak is_last.
- out_ack  in  1  Keccak consumed out_data this cycle.
- busy  out  1  state == STREAM.

Behaviour:
- Reset, asynchronous, resetb low: state=IDLE. All seed words=0, seed_loaded=0, write pointers=0. out_valid=0, out_data=0, out_last=0, req_err=0, busy=0. req_ready=1 and load_ready=1 once released.
- Storage: seed[NUM_SEEDS][SEED_WORDS] of DATA_W words, plus one write pointer per slot.
- load_ready = !(busy && load_sel == sel_q). A slot being streamed cannot be modified.
- load_clear && load_ready: clear seed_loaded[load_sel] and its write pointer. Clear takes priority over load_valid in the same cycle.
- load_valid && load_ready && !seed_loaded[load_sel]:
  - seed[load_sel][wptr] <= load_data; wptr increments.
  - On writing word SEED_WORDS-1: seed_loaded[load_sel] <= 1 and wptr wraps to 0.
- load_valid to an already loaded slot is ignored; the data is not written.
- load_sel >= NUM_SEEDS: load and clear are ignored.
- State IDLE:
  - req_ready=1, out_valid=0.
  - On req_valid: check seed_loaded[req_sel] using its registered value; a completion in the same cycle does not count.
  - If the slot is loaded and req_sel < NUM_SEEDS: latch sel_q and nonce_q, set ptr=0, go to STREAM.
  - Otherwise pulse req_err for one cycle and stay in IDLE.
- State STREAM:
  - req_ready=0, out_valid=1.
  - out_data = seed[sel_q][ptr] for ptr < SEED_WORDS; for ptr == SEED_WORDS, out_data = nonce_q zero-extended to DATA_W.
  - out_last = (ptr == SEED_WORDS).
  - On out_ack: if out_last, go to IDLE; else ptr++.
  - With no out_ack, out_data and out_last hold stable.
- Latency: request accepted at edge k gives out_valid=1 from cycle k+1. Total words per stream = SEED_WORDS+1. Back-to-back requests leave at least one IDLE cycle between streams.
- When out_valid=0, out_data=0 and out_last=0.
- ptr width = clog2(SEED_WORDS+1).
- out_ack while IDLE is ignored.
- Reset mid-stream: immediate return to IDLE with all seeds lost. The Keccak core is reset by the same resetb.

Optional Feature:
- Macro XOF_SEQ_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort in STREAM forces IDLE at the next edge; out_valid drops without any out_last.
  - abort has priority over out_ack in the same cycle.
  - Seed contents and seed_loaded are unchanged.
  - abort in IDLE is ignored.
- Undefined: no abort port. A stream always runs to out_last.

Test Plan:
- Load slot 0 with words 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> seed_loaded=2'b01 after the 4th edge. A 5th load_valid is ignored; contents unchanged.
- Request req_sel=0, req_nonce=16'h0201, out_ack held high -> out_data sequence 0x11..11, 0x22..22, 0x33..33, 0x44..44, 0x0000_0000_0000_0201. out_last only on the 5th word; IDLE next cycle.
- Request req_sel=1 while slot 1 is unloaded -> req_err=1 for exactly one cycle, req_ready stays 1, out_valid stays 0.
- Stream slot 0 with out_ack low for 3 cycles on word 2 -> out_data holds 0x33..33. load_clear with load_sel=0 during the stream -> load_ready=0 and seed_loaded[0] remains 1.
- Drive resetb low on the 3rd stream word -> out_valid=0, seed_loaded=0, req_ready=1 after release. A following request returns req_err.
- With XOF_SEQ_ABORT_EN: abort and out_ack together on word 1 -> IDLE next cycle, no out_last seen. A re-request streams from word 0.

Source files
------------

// File: rtl/xof_seed_sequencer_if.sv
// Handshake bundle between the seed sequencer, the Keccak output/absorb
// ports and the controller issuing seed loads and stream requests.
interface xof_seed_sequencer_if #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned NUM_SEEDS = 2,
  parameter int unsigned NONCE_W   = 16,
  parameter int unsigned SEL_W     = 1
);
  // Seed load path (from Keccak output)
  logic                 load_clear;
  logic                 load_valid;
  logic [SEL_W-1:0]     load_sel;
  logic [DATA_W-1:0]    load_data;
  logic                 load_ready;
  logic [NUM_SEEDS-1:0] seed_loaded;

  // Stream request
  logic                 req_valid;
  logic [SEL_W-1:0]     req_sel;
  logic [NONCE_W-1:0]   req_nonce;
  logic                 req_ready;
  logic                 req_err;

  // Stream out (to Keccak absorb port)
  logic                 out_valid;
  logic [DATA_W-1:0]    out_data;
  logic                 out_last;
  logic                 out_ack;
  logic                 busy;

  modport master (
    output load_clear, load_valid, load_sel, load_data,
    output req_valid, req_sel, req_nonce,
    output out_ack,
    input  load_ready, seed_loaded, req_ready, req_err,
    input  out_valid, out_data, out_last, busy
  );

  modport slave (
    input  load_clear, load_valid, load_sel, load_data,
    input  req_valid, req_sel, req_nonce,
    input  out_ack,
    output load_ready, seed_loaded, req_ready, req_err,
    output out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/xof_seed_sequencer.sv
// Seed store and XOF input sequencer. Holds NUM_SEEDS seeds loaded word by
// word from Keccak output and, on request, streams one seed followed by a
// zero-extended nonce word into the Keccak absorb port.
// Optional macro XOF_SEQ_ABORT_EN adds an 'abort' input that cancels a
// stream in flight without asserting out_last.
module xof_seed_sequencer #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned SEED_WORDS = 4,
  parameter int unsigned NUM_SEEDS  = 2,
  parameter int unsigned NONCE_W    = 16,
  parameter int unsigned SEL_W      = 1
) (
  input  logic clk,
  input  logic resetb,
`ifdef XOF_SEQ_ABORT_EN
  input  logic abort,
`endif
  xof_seed_sequencer_if.slave bus
);

  localparam int unsigned PTR_W  = $clog2(SEED_WORDS + 1);
  localparam int unsigned WPTR_W = (SEED_WORDS > 1) ? $clog2(SEED_WORDS) : 1;

  localparam logic [PTR_W-1:0]  LAST_PTR   = PTR_W'(SEED_WORDS);
  localparam logic [WPTR_W-1:0] LAST_WPTR  = WPTR_W'(SEED_WORDS - 1);
  localparam logic [SEL_W:0]    SLOT_LIMIT = (SEL_W + 1)'(NUM_SEEDS);

  typedef enum logic [0:0] {
    IDLE,
    STREAM
  } state_t;

  state_t               state_q, state_n;
  logic [SEL_W-1:0]     sel_q;
  logic [NONCE_W-1:0]   nonce_q;
  logic [PTR_W-1:0]     ptr_q;
  logic                 req_err_q;

  logic [DATA_W-1:0]    seed_mem [NUM_SEEDS][SEED_WORDS];
  logic [WPTR_W-1:0]    wptr_q   [NUM_SEEDS];
  logic [NUM_SEEDS-1:0] loaded_q;

  logic                 load_sel_ok;
  logic                 req_sel_ok;
  logic                 load_ready_w;
  logic                 req_accept;
  logic                 req_reject;
  logic                 stream_adv;
  logic                 abort_i;

  logic                 out_valid_w;
  logic                 out_last_w;
  logic [DATA_W-1:0]    out_data_w;

`ifdef XOF_SEQ_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  assign load_sel_ok  = {1'b0, bus.load_sel} < SLOT_LIMIT;
  assign req_sel_ok   = {1'b0, bus.req_sel} < SLOT_LIMIT;
  // The slot currently being streamed is write-protected for the whole stream.
  assign load_ready_w = !((state_q == STREAM) && (bus.load_sel == sel_q));

  // Next-state decode: accept/reject requests in IDLE, walk the stream in STREAM
  always_comb begin
    state_n    = state_q;
    req_accept = 1'b0;
    req_reject = 1'b0;
    stream_adv = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          // Registered loaded flag: a slot completing this same cycle is not yet eligible.
          if (req_sel_ok && loaded_q[bus.req_sel]) begin
            req_accept = 1'b1;
            state_n    = STREAM;
          end else begin
            req_reject = 1'b1;
          end
        end
      end
      STREAM: begin
        if (abort_i) begin
          state_n = IDLE;
        end else if (bus.out_ack) begin
          if (ptr_q == LAST_PTR) begin
            state_n = IDLE;
          end else begin
            stream_adv = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register plus latched request context and stream pointer
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      nonce_q   <= '0;
      ptr_q     <= '0;
      req_err_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      req_err_q <= req_reject;
      if (req_accept) begin
        sel_q   <= bus.req_sel;
        nonce_q <= bus.req_nonce;
        ptr_q   <= '0;
      end else if (stream_adv) begin
        ptr_q <= ptr_q + 1'b1;
      end
    end
  end

  // Seed storage: clear beats load; loaded slots ignore further words
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      for (int unsigned s = 0; s < NUM_SEEDS; s++) begin
        for (int unsigned w = 0; w < SEED_WORDS; w++) begin
          seed_mem[s][w] <= '0;
        end
        wptr_q[s] <= '0;
      end
      loaded_q <= '0;
    end else if (load_sel_ok && load_ready_w) begin
      if (bus.load_clear) begin
        loaded_q[bus.load_sel] <= 1'b0;
        wptr_q[bus.load_sel]   <= '0;
      end else if (bus.load_valid && !loaded_q[bus.load_sel]) begin
        seed_mem[bus.load_sel][wptr_q[bus.load_sel]] <= bus.load_data;
        if (wptr_q[bus.load_sel] == LAST_WPTR) begin
          loaded_q[bus.load_sel] <= 1'b1;
          wptr_q[bus.load_sel]   <= '0;
        end else begin
          wptr_q[bus.load_sel] <= wptr_q[bus.load_sel] + 1'b1;
        end
      end
    end
  end

  // Stream word mux: seed words first, then the nonce word; zero when idle
  always_comb begin
    out_valid_w = 1'b0;
    out_last_w  = 1'b0;
    out_data_w  = '0;
    if (state_q == STREAM) begin
      out_valid_w = 1'b1;
      out_last_w  = (ptr_q == LAST_PTR);
      if (out_last_w) begin
        out_data_w = DATA_W'(nonce_q);
      end else begin
        out_data_w = seed_mem[sel_q][ptr_q[WPTR_W-1:0]];
      end
    end
  end

  assign bus.load_ready  = load_ready_w;
  assign bus.seed_loaded = loaded_q;
  assign bus.req_ready   = (state_q == IDLE);
  assign bus.req_err     = req_err_q;
  assign bus.out_valid   = out_valid_w;
  assign bus.out_data    = out_data_w;
  assign bus.out_last    = out_last_w;
  assign bus.busy        = (state_q == STREAM);

endmodule
